// File: rtl/seq_count_pkg.sv
// Shared types and defaults for the sequential-counter family.
package seq_count_pkg;

    localparam int unsigned NBITS_DFLT = 3;

    typedef enum logic {
        COUNT_WRAP = 1'b0,
        COUNT_SAT  = 1'b1
    } count_mode_e;

endpackage

// File: rtl/seq_count_next.sv
// Next-state logic for the up/down counter: priority clear > load > en > hold.
module seq_count_next
    import seq_count_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DFLT,
    parameter int unsigned MAX   = (1 << NBITS) - 1,
    parameter count_mode_e MODE  = COUNT_WRAP
) (
    input  logic [NBITS-1:0] out,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    output logic [NBITS-1:0] next_out,
    output logic             next_tc
);

    localparam logic [NBITS-1:0] MAX_V = NBITS'(MAX);

    // Range-end tests happen before the arithmetic, so out+1 never overflows.
    always_comb begin
        next_out = out;
        next_tc  = 1'b0;
        if (clear) begin
            next_out = '0;
        end else if (load) begin
            next_out = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up) begin
                if (out == MAX_V) begin
                    next_tc  = 1'b1;
                    next_out = (MODE == COUNT_SAT) ? MAX_V : '0;
                end else begin
                    next_out = out + NBITS'(1);
                end
            end else begin
                if (out == '0) begin
                    next_tc  = 1'b1;
                    next_out = (MODE == COUNT_SAT) ? '0 : MAX_V;
                end else begin
                    next_out = out - NBITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seq_count_nb_bin_updown.sv
// Parametrised binary up/down counter with clear, load, wrap/saturate and terminal-count flags.
module seq_count_nb_bin_updown
    import seq_count_pkg::*;
#(
    parameter int unsigned NBITS    = NBITS_DFLT,
    parameter int unsigned MAX      = (1 << NBITS) - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [NBITS-1:0] out,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam count_mode_e      MODE  = (SATURATE != 0) ? COUNT_SAT : COUNT_WRAP;
    localparam logic [NBITS-1:0] MAX_V = NBITS'(MAX);

    logic [NBITS-1:0] next_out;
    logic             next_tc;

    seq_count_next #(
        .NBITS (NBITS),
        .MAX   (MAX),
        .MODE  (MODE)
    ) u_next (
        .out      (out),
        .en       (en),
        .up       (up),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .next_out (next_out),
        .next_tc  (next_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
            tc  <= 1'b0;
        end else begin
            out <= next_out;
            tc  <= next_tc;
        end
    end

    // Range-end flags decode straight from the registered count.
    assign at_max = (out == MAX_V);
    assign at_min = (out == '0);

endmodule

// File: tb/tb_seq_count_nb_bin_updown.sv
// Bench: six counter configurations share one stimulus stream and are checked against a behavioural model.
module tb_seq_count_nb_bin_updown;

    localparam int NI = 6;

    function automatic int unsigned cfg_max(int i);
        case (i)
            0:       return 7;
            1:       return 5;
            2:       return 5;
            3:       return 1;
            4:       return 1;
            default: return 7;
        endcase
    endfunction

    function automatic int unsigned cfg_sat(int i);
        return (i == 2 || i == 4 || i == 5) ? 1 : 0;
    endfunction

    logic       clk;
    logic       reset;
    logic       clear;
    logic       load;
    logic [2:0] load_val;
    logic       en;
    logic       up;

    logic [2:0] out_v  [NI];
    logic       tc_v   [NI];
    logic       amax_v [NI];
    logic       amin_v [NI];

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt [NI];
    int m_tc  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_count_nb_bin_updown #(
            .NBITS    (3),
            .MAX      (cfg_max(g)),
            .SATURATE (cfg_sat(g))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .load     (load),
            .load_val (load_val),
            .en       (en),
            .up       (up),
            .out      (out_v[g]),
            .tc       (tc_v[g]),
            .at_max   (amax_v[g]),
            .at_min   (amin_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clocked step from the rules, using plain integers.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int mx;
            mx = int'(cfg_max(i));
            m_tc[i] = 0;
            if (clear) begin
                m_cnt[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
            end else if (en) begin
                if (up) begin
                    if (m_cnt[i] == mx) begin
                        m_tc[i]  = 1;
                        m_cnt[i] = (cfg_sat(i) != 0) ? mx : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    if (m_cnt[i] == 0) begin
                        m_tc[i]  = 1;
                        m_cnt[i] = (cfg_sat(i) != 0) ? 0 : mx;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("out[%0d]", i), int'(out_v[i]), m_cnt[i]);
            check($sformatf("tc[%0d]", i), int'(tc_v[i]), m_tc[i]);
            check($sformatf("at_max[%0d]", i), int'(amax_v[i]),
                  (m_cnt[i] == int'(cfg_max(i))) ? 1 : 0);
            check($sformatf("at_min[%0d]", i), int'(amin_v[i]), (m_cnt[i] == 0) ? 1 : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) model_step();
        check_all();
    endtask

    // Assert reset away from any edge, check the immediate effect, release before next edge.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
        end
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; load = 1'b0; load_val = 3'd0; en = 1'b0; up = 1'b1;
    endtask

    initial begin
        int e_up [10];
        int e_dn [8];
        e_up = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        e_dn = '{5, 4, 3, 2, 1, 0, 5, 4};
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
        end

        reset = 1'b0;
        idle_inputs();
        #2;
        check_all();
        check("reset_at_min", int'(amin_v[0]), 1);
        check("reset_at_max", int'(amax_v[0]), 0);
        @(negedge clk);
        reset = 1'b1;

        // Wrap count up, MAX=7.
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("up7_out_%0d", k), int'(out_v[0]), e_up[k]);
            check($sformatf("up7_tc_%0d", k), int'(tc_v[0]), (k == 7) ? 1 : 0);
        end

        // Wrap count down from reset, MAX=5.
        idle_inputs();
        do_reset();
        en = 1'b1; up = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("dn5_out_%0d", k), int'(out_v[1]), e_dn[k]);
            check($sformatf("dn5_tc_%0d", k), int'(tc_v[1]), (k == 0 || k == 6) ? 1 : 0);
        end

        // Saturate at MAX=5 after load 4.
        idle_inputs();
        load = 1'b1; load_val = 3'd4;
        step();
        check("sat_load4", int'(out_v[2]), 4);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("sat_out_%0d", k), int'(out_v[2]), 5);
            check($sformatf("sat_tc_%0d", k), int'(tc_v[2]), (k > 0) ? 1 : 0);
            check($sformatf("sat_at_max_%0d", k), int'(amax_v[2]), 1);
        end

        // Load clamp and clear/load/en priority.
        idle_inputs();
        load = 1'b1; load_val = 3'd7;
        step();
        check("clamp_max5", int'(out_v[1]), 5);
        check("load7_max7", int'(out_v[0]), 7);
        clear = 1'b1; load = 1'b1; en = 1'b1;
        step();
        check("clr_wins_out", int'(out_v[1]), 0);
        check("clr_wins_tc", int'(tc_v[1]), 0);
        clear = 1'b0; load = 1'b1; en = 1'b1; load_val = 3'd2;
        step();
        check("load_wins_out", int'(out_v[1]), 2);
        check("load_wins_tc", int'(tc_v[1]), 0);

        // Async reset mid-count.
        idle_inputs();
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (3) step();
        check("pre_rst_cnt", int'(out_v[0]), 3);
        do_reset();
        check("async_rst_out", int'(out_v[0]), 0);
        check("async_rst_tc", int'(tc_v[0]), 0);
        step();
        check("post_rst_out", int'(out_v[0]), 1);

        // Random stimulus with occasional reset.
        for (int k = 0; k < 200; k++) begin
            clear    = ($urandom_range(0, 9) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 3'($urandom_range(0, 7));
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 2) != 0) ? (k < 100) : (k >= 100);
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_count_nb_bin_updown.md
# seq_count_nb_bin_updown

Parametrised binary up/down counter: a successor to the fixed 3-bit enable-only up counter, generalised in width, modulus and overflow mode. Adds synchronous clear, parallel load, direction control and terminal-count flags. Used as the common event/index counter primitive under timers, FIFO pointers and test sequencers in the sequential-counter family.

## Interface
- NBITS, 3, counter width in bits (≥1)
- MAX, 2**NBITS-1, highest legal count; count range is 0..MAX (1 ≤ MAX ≤ 2**NBITS-1)
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  NBITS  value for load
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- out  output  NBITS  current count, registered
- tc  output  1  terminal-count pulse, registered
- at_max  output  1  combinational: out == MAX
- at_min  output  1  combinational: out == 0

## Operation
- Priority per cycle: clear > load > en > hold.
- clear=1: out ← 0; tc ← 0.
- load=1: out ← min(load_val, MAX); values above MAX are clamped to MAX. tc ← 0.
- en=1, up=1: out < MAX → out+1. out == MAX → 0 in wrap mode, or MAX in saturate mode.
- en=1, up=0: out > 0 → out−1. out == 0 → MAX in wrap mode, or 0 in saturate mode.
- tc ← 1 for exactly one cycle after any enabled step that starts at the range end in the counting direction: MAX with up=1, or 0 with up=0. This holds in both modes. Otherwise tc ← 0.
- en=0 with no clear/load: out holds; tc ← 0.
- Arithmetic is NBITS wide with no carry out. MAX compare is done before increment, so no transient overflow occurs when MAX = 2**NBITS−1.
- at_max and at_min depend only on out. Both are 1 only when MAX=0, which is illegal.

## Timing
- Reset: asserting reset=0 forces out=0 and tc=0 immediately, with no clock needed. at_min=1 and at_max=0 during reset.
- Reset deassertion is synchronised by the environment. The first count can occur on the first rising edge with reset=1.
- Latency: one cycle from inputs to out/tc. Inputs are sampled on the rising edge; the new out is visible after that edge.
- Reset mid-count: the count is lost and restarts from 0. A pending tc is dropped.
- Simultaneous clear and load: clear wins. Simultaneous load and en: load wins, and no tc is produced.
- Direction change takes effect on the same edge as it is sampled. No turnaround cycle.

## Structure
- Shared package `seq_count_pkg`: localparam defaults NBITS_DFLT=3, and enum `count_mode_e` {COUNT_WRAP, COUNT_SAT} that maps to SATURATE.
- One natural sub-module, `seq_count_next`: purely combinational. Inputs are out, en, up, clear, load, load_val and the parameters. Outputs are next_out and next_tc.
- The top level holds only the async-reset state register plus the at_max/at_min decode.

## Test plan
- NBITS=3, MAX=7, wrap: reset, en=1 up=1 for 10 cycles → out 1,2,…,7,0,1,2. tc=1 only in the cycle out shows 0 after 7.
- NBITS=3, MAX=5, wrap, up=0 from reset: en=1 for 8 cycles → out 5,4,3,2,1,0,5,4. tc=1 in the cycle out first shows 5 (leaving 0) and again after 0→5.
- NBITS=3, MAX=5, SATURATE=1: load 4, then en=1 up=1 for 4 cycles → out 4,5,5,5,5. tc=1 on each of the 3 held cycles. at_max=1 from the first 5 onward.
- Load/clear priority: load=1 load_val=7 with MAX=5 → out=5. Next cycle clear=1 load=1 en=1 → out=0, tc=0. load=1 en=1 load_val=2 → out=2.
- Async reset mid-operation: count to 3, drop reset=0 at mid-cycle (no clock edge) → out=0 and tc=0 immediately. Release reset, en=1 → out 1 after the next edge.
- Random: 200 cycles of random clear/load/load_val/en/up plus occasional reset, in both modes, MAX ∈ {1,5,7}. Compare out/tc/at_max/at_min against a behavioural model every cycle.
